// File: rtl/vending_pkg.sv
// Shared encodings for the coin front end and the vending FSM.
// Coin codes double as the vending FSM's w input encoding.
package vending_pkg;

   // Coin codes as presented on coin_code
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_05   = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_20   = 2'b11;

   // Channel index of each switch inside the packed event vector
   localparam int CH_05 = 0;
   localparam int CH_10 = 1;
   localparam int CH_20 = 2;
   localparam int NUM_CH = 3;

   // Vending FSM state encoding (consumer of the coin stream)
   typedef enum logic [2:0] {
      VEND_IDLE    = 3'd0,
      VEND_CRED_05 = 3'd1,
      VEND_CRED_10 = 3'd2,
      VEND_CRED_15 = 3'd3,
      VEND_DISPENSE = 3'd4,
      VEND_CHANGE  = 3'd5
   } vend_state_e;

   // Highest-value coin among the events of one cycle; lower ones are dropped
   function automatic logic [1:0] coin_priority(input logic [NUM_CH-1:0] ev);
      logic [1:0] code;
      code = COIN_NONE;
      if (ev[CH_20])      code = COIN_20;
      else if (ev[CH_10]) code = COIN_10;
      else if (ev[CH_05]) code = COIN_05;
      return code;
   endfunction

   // True when two or more channels fired in the same cycle
   function automatic logic multi_event(input logic [NUM_CH-1:0] ev);
      return (ev[CH_05] & ev[CH_10]) | (ev[CH_05] & ev[CH_20]) | (ev[CH_10] & ev[CH_20]);
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-FF synchronizer, debounce counter, stable level and a
// registered one-cycle press pulse on the stable 1->0 transition.
module coin_debounce
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock_in,
   input  logic rst_n,
   input  logic sw_n_i,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          stable_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // Counter runs while the synchronized level disagrees with the stable one;
   // after DEBOUNCE_CYCLES disagreeing cycles the stable level adopts it.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // stable_q went low on the previous edge: report one insertion
      press_d = stable_dly_q & ~stable_q;
   end

   // Synchronizer, debounce state and press pulse registers
   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         stable_q     <= 1'b1;
         stable_dly_q <= 1'b1;
         cnt_q        <= '0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= sw_n_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         press_q      <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: three debounced switch channels, a priority
// encoder for same-cycle insertions, and a show-ahead coin FIFO with
// reject/overflow reporting toward the vending FSM.
module coin_acceptor
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEPTH           = 4
) (
   input  logic                     clock_in,
   input  logic                     rst_n,
   input  logic                     tin_05,
   input  logic                     tin_10,
   input  logic                     tin_20,
   input  logic                     coin_ready,
   output logic                     coin_valid,
   output logic [1:0]               coin_code,
   output logic                     coin_reject,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam logic [FW-1:0] FULL_LEVEL = FW'(DEPTH);

   logic [NUM_CH-1:0] raw_n;
   logic [NUM_CH-1:0] press;

   logic [1:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FW-1:0] fill_q, fill_d;
   logic          valid_q, valid_d;
   logic [1:0]    code_q, code_d;
   logic          reject_q, reject_d;
   logic          overflow_q, overflow_d;

   logic          push_valid, push, pop, full, drop;
   logic [1:0]    push_code;

   assign raw_n[CH_05] = tin_05;
   assign raw_n[CH_10] = tin_10;
   assign raw_n[CH_20] = tin_20;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
         coin_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock_in (clock_in),
            .rst_n    (rst_n),
            .sw_n_i   (raw_n[gi]),
            .press_o  (press[gi])
         );
      end
   endgenerate

   // Push/pop decision, pointer and level update, and next registered head
   always_comb begin
      push_valid = |press;
      push_code  = coin_priority(press);
      pop        = valid_q & coin_ready;
      full       = (fill_q == FULL_LEVEL);
      // A full FIFO still accepts when the head leaves in the same cycle
      push       = push_valid & (~full | pop);
      drop       = push_valid & full & ~pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      fill_d = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      valid_d = (fill_d != '0);
      // The new head may be the entry being written this cycle (empty FIFO,
      // or single entry popped while a new one arrives)
      if (!valid_d)
         code_d = COIN_NONE;
      else if (push && (rd_ptr_d == wr_ptr_q))
         code_d = push_code;
      else
         code_d = mem_q[rd_ptr_d];

      reject_d   = drop | multi_event(press);
      overflow_d = overflow_q | drop;
   end

   // FIFO storage; contents need no reset since the level qualifies them
   always_ff @(posedge clock_in) begin
      if (push)
         mem_q[wr_ptr_q] <= push_code;
   end

   // Pointers, level and registered outputs
   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         valid_q    <= 1'b0;
         code_q     <= COIN_NONE;
         reject_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         reject_q   <= reject_d;
         overflow_q <= overflow_d;
      end
   end

   assign coin_valid  = valid_q;
   assign coin_code   = code_q;
   assign coin_reject = reject_q;
   assign overflow    = overflow_q;
   assign fill_level  = fill_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, DEPTH=4.
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tin_05 = 1'b1;
   logic       tin_10 = 1'b1;
   logic       tin_20 = 1'b1;
   logic       coin_ready = 1'b0;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       coin_reject;
   logic       overflow;
   logic [2:0] fill_level;

   int checks = 0;
   int failures = 0;
   int rej_total = 0;
   int rej_base;

   coin_acceptor #(
      .DEBOUNCE_CYCLES (4),
      .DEPTH           (4)
   ) dut (
      .clock_in    (clk),
      .rst_n       (rst_n),
      .tin_05      (tin_05),
      .tin_10      (tin_10),
      .tin_20      (tin_20),
      .coin_ready  (coin_ready),
      .coin_valid  (coin_valid),
      .coin_code   (coin_code),
      .coin_reject (coin_reject),
      .overflow    (overflow),
      .fill_level  (fill_level)
   );

   always #5 clk = ~clk;

   // Count reject pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (coin_reject === 1'b1)
         rej_total <= rej_total + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ch: 0=5Tk, 1=10Tk, 2=20Tk
   task automatic set_sw(input int ch, input logic lvl);
      case (ch)
         0: tin_05 = lvl;
         1: tin_10 = lvl;
         default: tin_20 = lvl;
      endcase
   endtask

   task automatic press_coin(input int ch, input int low_n, input int high_n);
      set_sw(ch, 1'b0);
      tick(low_n);
      set_sw(ch, 1'b1);
      tick(high_n);
   endtask

   task automatic pop_one();
      $display("pop code=%02b fill=%0d", coin_code, fill_level);
      coin_ready = 1'b1;
      tick(1);
      coin_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      checks++; if (coin_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", coin_valid); end
      checks++; if (coin_code !== 2'b00) begin failures++; $display("FAIL reset_code got=%02b exp=00", coin_code); end
      checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%0b exp=0", coin_reject); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single_coin();
      rej_base = rej_total;
      tin_10 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i == 7) begin
            checks++; if (coin_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_early got=%0b exp=0", coin_valid); end
         end
         if (i == 8) begin
            checks++; if (coin_valid !== 1'b1) begin failures++; $display("FAIL t1_valid_latency got=%0b exp=1", coin_valid); end
            checks++; if (coin_code !== 2'b10) begin failures++; $display("FAIL t1_code got=%02b exp=10", coin_code); end
         end
      end
      tin_10 = 1'b1;
      tick(10);
      checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL t1_one_entry got=%0d exp=1", fill_level); end
      checks++; if (rej_total - rej_base !== 0) begin failures++; $display("FAIL t1_no_reject got=%0d exp=0", rej_total - rej_base); end
      pop_one();
      checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL t1_fill_after_pop got=%0d exp=0", fill_level); end
      checks++; if (coin_code !== 2'b00) begin failures++; $display("FAIL t1_code_empty got=%02b exp=00", coin_code); end
   endtask

   task automatic test_bounce();
      press_coin(0, 3, 2);
      press_coin(0, 3, 12);
      checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL t2_bounce_fill got=%0d exp=0", fill_level); end
      press_coin(0, 10, 10);
      checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL t2_hold_fill got=%0d exp=1", fill_level); end
      checks++; if (coin_code !== 2'b01) begin failures++; $display("FAIL t2_hold_code got=%02b exp=01", coin_code); end
      pop_one();
   endtask

   task automatic test_simultaneous();
      rej_base = rej_total;
      tin_05 = 1'b0;
      tin_20 = 1'b0;
      tick(10);
      tin_05 = 1'b1;
      tin_20 = 1'b1;
      tick(10);
      checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL t3_fill got=%0d exp=1", fill_level); end
      checks++; if (coin_code !== 2'b11) begin failures++; $display("FAIL t3_code got=%02b exp=11", coin_code); end
      checks++; if (rej_total - rej_base !== 1) begin failures++; $display("FAIL t3_reject_pulses got=%0d exp=1", rej_total - rej_base); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t3_overflow got=%0b exp=0", overflow); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [1:0] exp_codes [4];
      exp_codes[0] = 2'b01; exp_codes[1] = 2'b10; exp_codes[2] = 2'b11; exp_codes[3] = 2'b01;
      rej_base = rej_total;
      for (int i = 0; i < 6; i++) press_coin(i % 3, 8, 8);
      checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL t4_fill got=%0d exp=4", fill_level); end
      checks++; if (rej_total - rej_base !== 2) begin failures++; $display("FAIL t4_reject_pulses got=%0d exp=2", rej_total - rej_base); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t4_overflow got=%0b exp=1", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (coin_code !== exp_codes[i]) begin failures++; $display("FAIL t4_drain_code%0d got=%02b exp=%02b", i, coin_code, exp_codes[i]); end
         pop_one();
      end
      checks++; if (coin_valid !== 1'b0) begin failures++; $display("FAIL t4_drained_valid got=%0b exp=0", coin_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_codes [4];
      exp_codes[0] = 2'b10; exp_codes[1] = 2'b11; exp_codes[2] = 2'b01; exp_codes[3] = 2'b10;
      press_coin(0, 8, 8);
      press_coin(1, 8, 8);
      press_coin(2, 8, 8);
      press_coin(0, 8, 8);
      checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL t5_prefill got=%0d exp=4", fill_level); end
      rej_base = rej_total;
      tin_10 = 1'b0;
      tick(7);
      coin_ready = 1'b1;
      tick(1);
      coin_ready = 1'b0;
      checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL t5_fill_pushpop got=%0d exp=4", fill_level); end
      tick(2);
      tin_10 = 1'b1;
      tick(10);
      checks++; if (rej_total - rej_base !== 0) begin failures++; $display("FAIL t5_no_reject got=%0d exp=0", rej_total - rej_base); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (coin_code !== exp_codes[i]) begin failures++; $display("FAIL t5_drain_code%0d got=%02b exp=%02b", i, coin_code, exp_codes[i]); end
         pop_one();
      end
   endtask

   task automatic test_reset_midway();
      press_coin(0, 8, 8);
      press_coin(1, 8, 8);
      checks++; if (fill_level !== 3'd2) begin failures++; $display("FAIL t6_prefill got=%0d exp=2", fill_level); end
      tin_20 = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      checks++; if (coin_valid !== 1'b0) begin failures++; $display("FAIL t6_valid got=%0b exp=0", coin_valid); end
      checks++; if (coin_code !== 2'b00) begin failures++; $display("FAIL t6_code got=%02b exp=00", coin_code); end
      checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL t6_fill got=%0d exp=0", fill_level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t6_overflow got=%0b exp=0", overflow); end
      tick(3);
      rst_n = 1'b1;
      tick(7);
      checks++; if (coin_valid !== 1'b0) begin failures++; $display("FAIL t6_valid_early got=%0b exp=0", coin_valid); end
      tick(1);
      checks++; if (coin_valid !== 1'b1) begin failures++; $display("FAIL t6_valid_latency got=%0b exp=1", coin_valid); end
      checks++; if (coin_code !== 2'b11) begin failures++; $display("FAIL t6_code_held got=%02b exp=11", coin_code); end
      tin_20 = 1'b1;
      tick(12);
      checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL t6_one_entry got=%0d exp=1", fill_level); end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_single_coin();
      test_bounce();
      test_simultaneous();
      test_overflow();
      test_back_to_back();
      test_reset_midway();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
